// File: rtl/decode_seq_stage_if.sv
// decode_seq_stage_if: fetch-to-decode handshake plus the registered ID/EX
// slot produced by decode_seq_stage.
//   in_valid/in_ready/in_instr/in_pc : fetch word handshake
//   out_*                            : ID/EX register contents
// The master modport is the surrounding pipeline and the slave modport is the
// decode stage. Parameters must match those of the decode_seq_stage instance.
interface decode_seq_stage_if #(
   parameter int DATA_W  = 16,
   parameter int REG_CNT = 8,
   parameter int PC_W    = 32
);
   localparam int AW = $clog2(REG_CNT);

   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_instr;
   logic [PC_W-1:0]   in_pc;

   logic              out_valid;
   logic [4:0]        out_opcode;
   logic [DATA_W-1:0] out_rsrc;
   logic [DATA_W-1:0] out_rdst;
   logic [AW-1:0]     out_rsrc_addr;
   logic [AW-1:0]     out_rdst_addr;
   logic [DATA_W-1:0] out_push_data;
   logic              out_push;
   logic              out_call;
   logic              out_int;
   logic              out_second;
   logic              out_flush;

   modport master (
      output in_valid, in_instr, in_pc,
      input  in_ready,
      input  out_valid, out_opcode, out_rsrc, out_rdst, out_rsrc_addr,
             out_rdst_addr, out_push_data, out_push, out_call, out_int,
             out_second, out_flush
   );

   modport slave (
      input  in_valid, in_instr, in_pc,
      output in_ready,
      output out_valid, out_opcode, out_rsrc, out_rdst, out_rsrc_addr,
             out_rdst_addr, out_push_data, out_push, out_call, out_int,
             out_second, out_flush
   );
endinterface

// File: rtl/decode_seq_stage.sv
// decode_seq_stage: instruction decode stage with register file, load-use
// hazard stall, and a sequencer that expands CALL and interrupt entry into
// two stack-push slots followed by a pipeline flush slot.
// Ports:
//   Clk, Rst                : clock (rising edge), asynchronous active-low reset
//   bus (slave)             : fetch handshake in, registered ID/EX slot out
//   intr_req                : level interrupt request, latched as pending
//   ex_flush                : branch-taken flush from EX, drops the accepted word
//   wb_en/wb_addr/wb_data   : register file write-back
//   ex_memread/ex_rdst      : load currently in EX, used for hazard detection
// Optional feature: define WB_BYPASS_EN to make a same-cycle write-back visible
// to the register read (write-through); otherwise the pre-write value is read.
// Instruction layout: [15:11] opcode, [10 -: AW] rsrc, [10-AW -: AW] rdst.
module decode_seq_stage #(
   parameter int         DATA_W  = 16,
   parameter int         REG_CNT = 8,
   parameter int         PC_W    = 32,
   parameter logic [4:0] CALL_OP = 5'b11010,
   localparam int        AW      = $clog2(REG_CNT)
) (
   input  logic              Clk,
   input  logic              Rst,
   decode_seq_stage_if.slave bus,
   input  logic              intr_req,
   input  logic              ex_flush,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_memread,
   input  logic [AW-1:0]     ex_rdst
);

   typedef enum logic [2:0] {S_IDLE, S_CALL2, S_INT1, S_INT2, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic [PC_W-1:0]   pc_save_q, pc_save_d;
   logic [DATA_W-1:0] regs_q [REG_CNT];
   logic [DATA_W-1:0] regs_d [REG_CNT];

   logic              valid_q, valid_d;
   logic [4:0]        opcode_q, opcode_d;
   logic [DATA_W-1:0] rsrc_q, rsrc_d;
   logic [DATA_W-1:0] rdst_q, rdst_d;
   logic [AW-1:0]     rsrc_addr_q, rsrc_addr_d;
   logic [AW-1:0]     rdst_addr_q, rdst_addr_d;
   logic [DATA_W-1:0] push_data_q, push_data_d;
   logic              push_q, push_d;
   logic              call_q, call_d;
   logic              intr_q, intr_d;
   logic              second_q, second_d;
   logic              flush_q, flush_d;

   logic [4:0]        opcode;
   logic [AW-1:0]     rsrc_addr, rdst_addr;
   logic [DATA_W-1:0] rsrc_val, rdst_val;
   logic              hazard, in_ready, accept;
   logic              unused_instr_bits;

   assign opcode            = bus.in_instr[15:11];
   assign rsrc_addr         = bus.in_instr[10 -: AW];
   assign rdst_addr         = bus.in_instr[10-AW -: AW];
   assign unused_instr_bits = ^bus.in_instr[10-2*AW:0];

   assign hazard   = ex_memread && ((ex_rdst == rsrc_addr) || (ex_rdst == rdst_addr));
   // Reset is folded in so the stage never advertises readiness while held in reset.
   assign in_ready = Rst && (state_q == S_IDLE) && !pending_q && !hazard;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      rsrc_val = regs_q[rsrc_addr];
      rdst_val = regs_q[rdst_addr];
`ifdef WB_BYPASS_EN
      if (wb_en && (wb_addr == rsrc_addr)) rsrc_val = wb_data;
      if (wb_en && (wb_addr == rdst_addr)) rdst_val = wb_data;
`endif
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_en) regs_d[wb_addr] = wb_data;
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q | intr_req;
      pc_save_d   = pc_save_q;
      valid_d     = 1'b0;
      opcode_d    = '0;
      rsrc_d      = '0;
      rdst_d      = '0;
      rsrc_addr_d = '0;
      rdst_addr_d = '0;
      push_data_d = '0;
      push_d      = 1'b0;
      call_d      = 1'b0;
      intr_d      = 1'b0;
      second_d    = 1'b0;
      flush_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pending_q && !hazard) begin
               // Interrupt entry: the presented word stays unaccepted and its
               // PC becomes the return address pushed by INT1/INT2.
               state_d   = S_INT1;
               pending_d = 1'b0;
               pc_save_d = bus.in_pc;
            end else if (accept && !ex_flush) begin
               valid_d     = 1'b1;
               opcode_d    = opcode;
               rsrc_d      = rsrc_val;
               rdst_d      = rdst_val;
               rsrc_addr_d = rsrc_addr;
               rdst_addr_d = rdst_addr;
               if (opcode == CALL_OP) begin
                  call_d      = 1'b1;
                  push_d      = 1'b1;
                  push_data_d = bus.in_pc[DATA_W-1:0];
                  pc_save_d   = bus.in_pc;
                  state_d     = S_CALL2;
               end
            end
         end
         S_CALL2: begin
            push_d      = 1'b1;
            second_d    = 1'b1;
            push_data_d = pc_save_q[DATA_W +: DATA_W];
            state_d     = S_FLUSH;
         end
         S_INT1: begin
            intr_d      = 1'b1;
            push_d      = 1'b1;
            push_data_d = pc_save_q[DATA_W-1:0];
            state_d     = S_INT2;
         end
         S_INT2: begin
            intr_d      = 1'b1;
            push_d      = 1'b1;
            second_d    = 1'b1;
            push_data_d = pc_save_q[DATA_W +: DATA_W];
            state_d     = S_FLUSH;
         end
         S_FLUSH: begin
            flush_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= S_IDLE;
         pending_q   <= 1'b0;
         pc_save_q   <= '0;
         regs_q      <= '{default: '0};
         valid_q     <= 1'b0;
         opcode_q    <= '0;
         rsrc_q      <= '0;
         rdst_q      <= '0;
         rsrc_addr_q <= '0;
         rdst_addr_q <= '0;
         push_data_q <= '0;
         push_q      <= 1'b0;
         call_q      <= 1'b0;
         intr_q      <= 1'b0;
         second_q    <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         pc_save_q   <= pc_save_d;
         regs_q      <= regs_d;
         valid_q     <= valid_d;
         opcode_q    <= opcode_d;
         rsrc_q      <= rsrc_d;
         rdst_q      <= rdst_d;
         rsrc_addr_q <= rsrc_addr_d;
         rdst_addr_q <= rdst_addr_d;
         push_data_q <= push_data_d;
         push_q      <= push_d;
         call_q      <= call_d;
         intr_q      <= intr_d;
         second_q    <= second_d;
         flush_q     <= flush_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = valid_q;
   assign bus.out_opcode    = opcode_q;
   assign bus.out_rsrc      = rsrc_q;
   assign bus.out_rdst      = rdst_q;
   assign bus.out_rsrc_addr = rsrc_addr_q;
   assign bus.out_rdst_addr = rdst_addr_q;
   assign bus.out_push_data = push_data_q;
   assign bus.out_push      = push_q;
   assign bus.out_call      = call_q;
   assign bus.out_int       = intr_q;
   assign bus.out_second    = second_q;
   assign bus.out_flush     = flush_q;

endmodule
